y86_cc_unit: RTL and testbench

Condition-code register and condition evaluator for the Y86-64 execute stage. It consumes the result and overflow outputs of the 64-bit add/sub ALU and registers ZF/SF/OF on each flag-setting operation. It answers jXX/cmovXX condition requests with a registered cnd bit and valid strobe. It also keeps a saturating count of overflow events for debug.

---
 rtl/y86_cc_unit.sv | 148 ++++++++++++++
 tb/tb_y86_cc_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/y86_cc_unit.sv
// Purpose : Y86-64 execute-stage condition codes (ZF/SF/OF) plus the jXX/cmovXX condition evaluator.
// Latency : a flag update is visible on cc one cycle after the edge; cond_req in cycle N gives cnd/cnd_valid in N+1.
// Backpressure: none. Every result and every request is accepted on the cycle it is presented.
//
// Ports:
//   clk, rst_n    rising-edge clock; asynchronous active-low reset
//   res_valid     ALU result valid; with set_cc, latches new flags into cc
//   alu_result    ALU sum output (WIDTH bits)
//   alu_overflow  ALU signed overflow output
//   set_cc        the current instruction updates CC (OPq)
//   cond_req      condition evaluation request
//   cond_ifun     ifun of the jXX/cmovXX being evaluated
//   cc            registered flags {ZF,SF,OF}
//   cnd           registered condition result; holds between requests
//   cnd_valid     one-cycle strobe per request
//   cond_err      registered; set when the answered request had ifun > 6
//   ovf_count     saturating count of CC updates with OF=1
//   ovf_clr       synchronous clear of ovf_count; wins over an increment
//
// Build option: define CC_BYPASS_EN so that a request arriving together with a
// flag update evaluates against the new flags instead of the registered cc.

module y86_cc_unit #(
    parameter int WIDTH     = 64,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 res_valid,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_overflow,
    input  logic                 set_cc,
    input  logic                 cond_req,
    input  logic [3:0]           cond_ifun,
    output logic [2:0]           cc,
    output logic                 cnd,
    output logic                 cnd_valid,
    output logic                 cond_err,
    output logic [OVF_CNT_W-1:0] ovf_count,
    input  logic                 ovf_clr
);

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } flags_t;

    // Result of evaluating one condition: the condition bit and an illegal-ifun flag.
    typedef struct packed {
        logic err;
        logic cnd;
    } eval_t;

    localparam flags_t FLAGS_RST = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    flags_t               cc_q, cc_d;
    flags_t               flags_n;
    flags_t               eval_flags;
    eval_t                eval_res;
    logic                 cnd_q, cnd_d;
    logic                 cnd_vld_q;
    logic                 cond_err_q, cond_err_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic                 cc_upd;

    function automatic eval_t cond_eval(input logic [3:0] ifun, input flags_t f);
        eval_t r;
        logic  lt;
        r  = '0;
        lt = f.sf ^ f.of;
        case (ifun)
            4'd0:    r.cnd = 1'b1;
            4'd1:    r.cnd = lt | f.zf;
            4'd2:    r.cnd = lt;
            4'd3:    r.cnd = f.zf;
            4'd4:    r.cnd = ~f.zf;
            4'd5:    r.cnd = ~lt;
            4'd6:    r.cnd = ~lt & ~f.zf;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    always_comb begin
        flags_n.zf = (alu_result == '0);
        flags_n.sf = alu_result[WIDTH-1];
        flags_n.of = alu_overflow;
    end

    assign cc_upd = res_valid & set_cc;

    // Y86 semantics: a request sees the flags as they stood before this
    // cycle's update. The bypass build forwards the update instead.
`ifdef CC_BYPASS_EN
    assign eval_flags = cc_upd ? flags_n : cc_q;
`else
    assign eval_flags = cc_q;
`endif

    assign eval_res = cond_eval(cond_ifun, eval_flags);

    always_comb begin
        cc_d       = cc_q;
        cnd_d      = cnd_q;
        cond_err_d = cond_err_q;
        ovf_cnt_d  = ovf_cnt_q;

        if (cc_upd) begin
            cc_d = flags_n;
        end

        // cnd/cond_err only move when a request is answered; otherwise they hold.
        if (cond_req) begin
            cnd_d      = eval_res.cnd;
            cond_err_d = eval_res.err;
        end

        if (ovf_clr) begin
            ovf_cnt_d = '0;
        end else if (cc_upd && flags_n.of && !(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q       <= FLAGS_RST;
            cnd_q      <= 1'b0;
            cnd_vld_q  <= 1'b0;
            cond_err_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            cc_q       <= cc_d;
            cnd_q      <= cnd_d;
            cnd_vld_q  <= cond_req;
            cond_err_q <= cond_err_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign cc        = cc_q;
    assign cnd       = cnd_q;
    assign cnd_valid = cnd_vld_q;
    assign cond_err  = cond_err_q;
    assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_y86_cc_unit.sv
// Purpose : self-checking bench for y86_cc_unit against a flag-level reference model.
// Latency : the model advances once per rising edge and is compared 1 time unit later.
// Backpressure: not applicable; stimulus is driven freely every cycle.

module tb_y86_cc_unit;

    localparam int W  = 64;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic          res_valid;
    logic [W-1:0]  alu_result;
    logic          alu_overflow;
    logic          set_cc;
    logic          cond_req;
    logic [3:0]    cond_ifun;
    logic [2:0]    cc;
    logic          cnd;
    logic          cnd_valid;
    logic          cond_err;
    logic [CW-1:0] ovf_count;
    logic          ovf_clr;

    y86_cc_unit #(.WIDTH(W), .OVF_CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_valid    (res_valid),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .set_cc       (set_cc),
        .cond_req     (cond_req),
        .cond_ifun    (cond_ifun),
        .cc           (cc),
        .cnd          (cnd),
        .cnd_valid    (cnd_valid),
        .cond_err     (cond_err),
        .ovf_count    (ovf_count),
        .ovf_clr      (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state, kept as plain booleans and an integer count.
    bit m_zf, m_sf, m_of;
    bit m_cnd, m_vld, m_err;
    int m_cnt;
    int pulses;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition truth table in terms of signed-comparison outcomes.
    function automatic bit truth(input int ifun, input bit zf, input bit sf, input bit of);
        bit less;
        bit equal;
        less  = (sf != of);
        equal = zf;
        case (ifun)
            0:       return 1'b1;
            1:       return less || equal;
            2:       return less;
            3:       return equal;
            4:       return !equal;
            5:       return !less;
            6:       return !less && !equal;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_zf = 1; m_sf = 0; m_of = 0;
        m_cnd = 0; m_vld = 0; m_err = 0;
        m_cnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_edge();
        bit upd, nz, ns, no, ez, es, eo;
        if (!rst_n) begin
            model_reset();
            return;
        end
        upd = res_valid && set_cc;
        nz  = (alu_result == 0);
        ns  = ($signed(alu_result) < 0);
        no  = alu_overflow;
        ez = m_zf; es = m_sf; eo = m_of;
`ifdef CC_BYPASS_EN
        if (upd) begin ez = nz; es = ns; eo = no; end
`endif
        m_vld = cond_req;
        if (cond_req) begin
            m_cnd = truth(int'(cond_ifun), ez, es, eo);
            m_err = (cond_ifun > 6);
        end
        if (upd) begin m_zf = nz; m_sf = ns; m_of = no; end
        if (ovf_clr) m_cnt = 0;
        else if (upd && no && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    endtask

    task automatic compare_all();
        check("cc",        64'(cc),        64'({m_zf, m_sf, m_of}));
        check("cnd",       64'(cnd),       64'(m_cnd));
        check("cnd_valid", 64'(cnd_valid), 64'(m_vld));
        check("cond_err",  64'(cond_err),  64'(m_err));
        check("ovf_count", 64'(ovf_count), 64'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
        if (cnd_valid) pulses++;
    endtask

    task automatic idle();
        res_valid = 0; set_cc = 0; cond_req = 0; ovf_clr = 0; alu_overflow = 0;
    endtask

    task automatic upd(input logic [W-1:0] r, input logic o);
        res_valid = 1; set_cc = 1; alu_result = r; alu_overflow = o;
    endtask

    task automatic req(input logic [3:0] f);
        cond_req = 1; cond_ifun = f;
    endtask

    initial begin
        rst_n = 0; alu_result = '0; cond_ifun = '0; pulses = 0;
        idle();
        model_reset();
        repeat (2) step();
        rst_n = 1;
        step();
        check("reset_cc_lit", 64'(cc), 64'(3'b100));

        // Equal on reset flags.
        req(4'd3); step(); idle();
        check("t1_cnd_lit", 64'(cnd), 64'd1);
        check("t1_vld_lit", 64'(cnd_valid), 64'd1);

        // Negative result: SF only.
        upd(-64'd310, 1'b0); step(); idle();
        check("t2_cc_lit", 64'(cc), 64'(3'b010));
        req(4'd2); step(); idle();
        check("t2_l_lit", 64'(cnd), 64'd1);
        req(4'd6); step(); idle();
        check("t2_g_lit", 64'(cnd), 64'd0);

        // res_valid without set_cc must not disturb cc.
        res_valid = 1; alu_result = '0; step(); idle();
        req(4'd4); step(); idle();
        check("t3_cc_lit", 64'(cc), 64'(3'b010));
        check("t3_ne_lit", 64'(cnd), 64'd1);

        // Same-cycle update and request against cc=000.
        upd(64'd5, 1'b0); step(); idle();
        upd(64'd0, 1'b0); req(4'd3); step(); idle();
`ifdef CC_BYPASS_EN
        check("t4_byp_lit", 64'(cnd), 64'd1);
`else
        check("t4_old_lit", 64'(cnd), 64'd0);
`endif
        check("t4_cc_lit", 64'(cc), 64'(3'b100));

        // Illegal ifun, then three back-to-back requests.
        req(4'd9); step(); idle();
        check("t5_err_lit", 64'(cond_err), 64'd1);
        check("t5_cnd_lit", 64'(cnd), 64'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin req(4'(i)); step(); end
        idle(); step();
        check("t5_pulses_lit", 64'(pulses), 64'd3);

        // Counter saturation then clear-wins.
        for (int i = 0; i < 5; i++) begin upd(64'(i + 1), 1'b1); step(); end
        idle();
        check("t6_sat_lit", 64'(ovf_count), 64'd3);
        upd(64'd7, 1'b1); ovf_clr = 1; step(); idle();
        check("t6_clr_lit", 64'(ovf_count), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            res_valid    = ($urandom_range(0, 3) != 0);
            set_cc       = $urandom_range(0, 1);
            alu_overflow = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       alu_result = '0;
                1:       alu_result = {1'b1, 63'($urandom)};
                default: alu_result = {$urandom, $urandom};
            endcase
            cond_req  = $urandom_range(0, 1);
            cond_ifun = 4'($urandom_range(0, 15));
            ovf_clr   = ($urandom_range(0, 31) == 0);
            step();
        end
        idle();

        // Reset in the middle of a pending request.
        upd(64'd9, 1'b1); req(4'd0);
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        check("rst_vld_lit", 64'(cnd_valid), 64'd0);
        check("rst_cc_lit", 64'(cc), 64'(3'b100));
        step();
        idle();
        @(negedge clk);
        rst_n = 1;
        step();
        step();
        check("post_rst_vld_lit", 64'(cnd_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
